regfile_param_init: RTL

//  Parametrised 2-read/1-write integer register file for the single-cycle RISC-V datapath.

---
 rtl/regfile_param_init_if.sv | 35 +++
 rtl/regfile_param_init.sv | 107 ++++++++++
 2 files changed

// File: rtl/regfile_param_init_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_param_init_if
// Description : Register-file access bundle: two read indices, one write
//               index/data/enable, two read data returns and the Ready flag.
//               master = datapath side driving indices/data,
//               slave  = register file side returning read data and Ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_param_init_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
);
  localparam int ADDR_W = $clog2(NREGS);

  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [ADDR_W-1:0] RegWrite;
  logic [XLEN-1:0]   WriteData;
  logic              WriteReg;
  logic [XLEN-1:0]   ReadData1;
  logic [XLEN-1:0]   ReadData2;
  logic              Ready;

  modport master (
    output ReadReg1, ReadReg2, RegWrite, WriteData, WriteReg,
    input  ReadData1, ReadData2, Ready
  );

  modport slave (
    input  ReadReg1, ReadReg2, RegWrite, WriteData, WriteReg,
    output ReadData1, ReadData2, Ready
  );
endinterface
`default_nettype wire

// File: rtl/regfile_param_init.sv
`default_nettype none
// ============================================================================
// Module      : regfile_param_init
// Description : Parametrised 2-read/1-write integer register file with an
//               after-reset init sequencer, optional hardwired x0 and
//               optional write-to-read bypass. Reads are combinational.
// Ports       : clk   - rising-edge clock
//               reset - synchronous active-high reset (restarts init)
//               bus   - regfile_param_init_if.slave: ReadReg1/2, RegWrite,
//                       WriteData, WriteReg in; ReadData1/2, Ready out
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_param_init #(
  parameter int XLEN      = 64,
  parameter int NREGS     = 32,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = 1,
  parameter int BYPASS    = 1,
  localparam int ADDR_W   = $clog2(NREGS)
) (
  input  logic clk,
  input  logic reset,
  regfile_param_init_if.slave bus
);

  localparam logic [0:0]      c_st_init  = 1'b0;
  localparam logic [0:0]      c_st_run   = 1'b1;
  // Last index written by the init sequencer; the counter carries one extra
  // bit so it can step past the final register without wrapping to 0.
  localparam logic [ADDR_W:0] c_last_idx = (ADDR_W+1)'(NREGS-1);

  logic [0:0]        r_state;
  logic [ADDR_W:0]   r_idx;
  logic [XLEN-1:0]   r_mem [NREGS];

  logic              w_run;
  logic              w_user_we;
  logic [XLEN-1:0]   w_init_val;

  assign w_run      = (r_state == c_st_run);
  assign w_init_val = (INIT_MODE != 0) ? XLEN'(r_idx[ADDR_W-1:0]) : '0;
  // Writes to x0 are dropped when x0 is hardwired.
  assign w_user_we  = w_run && bus.WriteReg &&
                      !((ZERO_REG != 0) && (bus.RegWrite == '0));

  // --------------------------------------------------------------------------
  // Init sequencer: one register per cycle, RUN entered on the edge that
  // writes the last register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_init;
      r_idx   <= '0;
    end else if (r_state == c_st_init) begin
      r_idx <= r_idx + (ADDR_W+1)'(1);
      if (r_idx == c_last_idx) begin
        r_state <= c_st_run;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage: no reset on the array itself; contents are defined by the init
  // sequence. Reset blocks every write, including a concurrent user write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == c_st_init) begin
        r_mem[r_idx[ADDR_W-1:0]] <= w_init_val;
      end else if (w_user_we) begin
        r_mem[bus.RegWrite] <= bus.WriteData;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read resolution, identical for both ports. The x0 check precedes the
  // bypass so a dropped x0 write never leaks through.
  // --------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] resolve_read(
    input logic              run,
    input logic [ADDR_W-1:0] raddr,
    input logic [XLEN-1:0]   stored,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [XLEN-1:0]   wdata
  );
    logic [XLEN-1:0] result;
    result = stored;
    if (!run) begin
      result = '0;
    end else if ((ZERO_REG != 0) && (raddr == '0)) begin
      result = '0;
    end else if ((BYPASS != 0) && we && (raddr == waddr)) begin
      result = wdata;
    end
    return result;
  endfunction

  assign bus.ReadData1 = resolve_read(w_run, bus.ReadReg1, r_mem[bus.ReadReg1],
                                      bus.WriteReg, bus.RegWrite, bus.WriteData);
  assign bus.ReadData2 = resolve_read(w_run, bus.ReadReg2, r_mem[bus.ReadReg2],
                                      bus.WriteReg, bus.RegWrite, bus.WriteData);
  assign bus.Ready     = w_run;

endmodule
`default_nettype wire
